shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences the datapath's single-step 16-bit shifter to perform shifts of 0–15 positions. It captures an operand, a shift code and an amount on a `start` request. It then drives the shared shifter once per clock, feeding each result back as the next input. When the count reaches zero it presents the result with a one-cycle `done` pulse. It sits between the control FSM and the shifter so that a multi-position shift instruction can reuse the existing 1-bit shift hardware.

## Interface
- No parameters; data width fixed at 16, amount width fixed at 4.
- `clk` input 1 — single clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state immediately.
- `start` input 1 — request; sampled on a rising edge only in IDLE or DONE.
- `in` input 16 — operand, captured with `start`.
- `op` input 2 — shift code, captured with `start`:
  - 00 pass
  - 01 logical left by 1
  - 10 logical right by 1
  - 11 arithmetic right by 1, MSB preserved
- `amount` input 4 — number of single-step shifts (0–15), captured with `start`.
- `sh_in` output 16 — operand to the shifter; always equals the internal accumulator.
- `shift` output 2 — code to the shifter; the captured `op` in SHIFT state, 00 otherwise.
- `sout` input 16 — combinational result from the shifter for (`sh_in`, `shift`).
- `out` output 16 — registered result; equals the accumulator.
- `busy` output 1 — high in SHIFT state only.
- `done` output 1 — high for exactly the one cycle spent in DONE state.

## Operation
- Registers:
  - `state`: IDLE, SHIFT or DONE.
  - `acc[15:0]`: accumulator.
  - `cnt[3:0]`: remaining steps.
  - `op_r[1:0]`: captured shift code.
- Reset values: `state`=IDLE, `acc`=0, `cnt`=0, `op_r`=00. Outputs therefore reset to `out`=0, `sh_in`=0, `shift`=00, `busy`=0, `done`=0.
- IDLE:
  - `start`=1: `acc`<=`in`, `cnt`<=`amount`, `op_r`<=`op`. Go to DONE if `amount`==0 or `op`==00, else to SHIFT.
  - `start`=0: hold all registers.
- SHIFT, every edge:
  - `acc`<=`sout`, `cnt`<=`cnt`-1.
  - If `cnt`==1, go to DONE; else stay in SHIFT.
  - `start` is ignored; no abort mechanism.
- DONE:
  - `done`=1 for the cycle.
  - `start`=1: capture as in IDLE (back-to-back operation allowed).
  - `start`=0: go to IDLE and hold `acc`.
- `out` keeps the last result stable through IDLE until the next accepted `start`.
- Arithmetic right shift replicates the MSB on each step, so a negative operand fills with ones.
- `cnt` never wraps. SHIFT is only entered with `cnt`≥1 and is left when `cnt` reaches 1, so `cnt` is 0 in DONE.
- Reset asserted mid-operation: all registers return to reset values asynchronously. No `done` pulse is produced for the aborted operation, and no partial result is retained.

## Timing
- Capture edge E0 = the rising edge on which `start` is accepted.
- `amount`=N>0 with `op`≠00:
  - SHIFT occupies the N cycles after E0; `busy`=1 throughout.
  - Shifts occur on edges E1..EN.
  - `done`=1 and the final `out` are valid in the cycle after EN.
  - Start-to-done latency is N+1 edges.
- N=0 or `op`==00: DONE in the cycle after E0, `out`=`in`, latency 1 edge.
- `shift`/`sh_in` are stable for the full SHIFT cycle. `sout` must settle within one clock period; this is a combinational path through the shifter.
- `done` and `busy` are never high together.
- Throughput with back-to-back starts: one operation per N+1 cycles.

## Test plan
- Reset mid-SHIFT: start `in`=0x1234, `op`=01, `amount`=8; assert `reset` after 3 edges -> `out`=0, `busy`=0, `done`=0 immediately, and no `done` pulse appears afterwards.
- Logical left: `in`=0x0001, `op`=01, `amount`=15 -> `busy` high 15 cycles; then `done` for one cycle with `out`=0x8000.
- Logical vs arithmetic right:
  - `in`=0x8000, `op`=10, `amount`=15 -> `out`=0x0001.
  - Same operand with `op`=11 -> `out`=0xFFFF, 16 edges from capture to `done`.
- Zero cases:
  - `amount`=0, `op`=01, `in`=0xBEEF -> `done` on the cycle after capture, `out`=0xBEEF, `busy` never high.
  - `op`=00, `amount`=7 -> same one-edge behaviour.
- Ignored start: start `in`=0x00F0, `op`=10, `amount`=4; hold `start`=1 with `in`=0xFFFF throughout SHIFT -> the first result is `out`=0x000F. The held start is accepted in the DONE cycle, so `out`=0xFFFF follows.
- Back-to-back:
  - In the DONE cycle, start `in`=0x0003, `op`=01, `amount`=2 -> next result `out`=0x000C.
  - `done` pulses exactly once per operation.
  - `shift` reads 00 in every non-SHIFT cycle.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps an external single-position shifter
// N times, feeding each result back, then pulses done with the final value.
module shift_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] in,
   input  logic [1:0]  op,
   input  logic [3:0]  amount,
   output logic [15:0] sh_in,
   output logic [1:0]  shift,
   input  logic [15:0] sout,
   output logic [15:0] out,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= 16'h0000;
         cnt_q   <= 4'd0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               acc_d = in;
               op_d  = op;
               // A zero amount or pass code needs no shifter steps at all.
               if ((amount == 4'd0) || (op == 2'b00)) begin
                  cnt_d   = 4'd0;
                  state_d = DONE;
               end else begin
                  cnt_d   = amount;
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            acc_d = sout;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sh_in     = acc_q;
   assign out       = acc_q;
   assign shift     = (state_q == SHIFT) ? op_q : 2'b00;
   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-step shifter
// closing the sh_in/shift -> sout loop.
module tb_shift_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] in;
   logic [1:0]  op;
   logic [3:0]  amount;
   logic [15:0] sh_in;
   logic [1:0]  shift;
   logic [15:0] sout;
   logic [15:0] out;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;

   shift_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in        (in),
      .op        (op),
      .amount    (amount),
      .sh_in     (sh_in),
      .shift     (shift),
      .sout      (sout),
      .out       (out),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-step shifter the sequencer drives
   always_comb begin
      case (shift)
         2'b00:   sout = sh_in;
         2'b01:   sout = {sh_in[14:0], 1'b0};
         2'b10:   sout = {1'b0, sh_in[15:1]};
         default: sout = {sh_in[15], sh_in[15:1]};
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the DONE cycle (or timeout).
   task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                         input logic [3:0] n, input logic [15:0] exp_out, input int exp_lat);
      int lat;
      int busy_cnt;
      int shift_bad;
      start = 1'b1; in = a; op = o; amount = n;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1; busy_cnt = 0; shift_bad = 0;
      while (!done && lat <= 40) begin
         if (busy) busy_cnt++;
         else if (shift !== 2'b00) shift_bad++;
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_latency"}, lat, exp_lat);
      check_eq({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
      check_eq({tag, "_out"}, out, exp_out);
      check_eq({tag, "_busy_at_done"}, busy, 1'b0);
      check_eq({tag, "_shift_idle"}, shift_bad + int'(shift), 0);
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int done_cnt;
      reset = 1'b1; start = 1'b0; in = 16'h0000; op = 2'b00; amount = 4'd0;
      #12;
      check_eq("rst_out", out, 16'h0000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_shift", shift, 2'b00);
      check_eq("rst_state", state_dbg, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset mid-SHIFT
      start = 1'b1; in = 16'h1234; op = 2'b01; amount = 4'd8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("mid_busy_before", busy, 1'b1);
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_out", out, 16'h0000);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_done", done, 1'b0);
      check_eq("mid_rst_state", state_dbg, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check_eq("mid_rst_no_done", done_cnt, 0);
      check_eq("mid_rst_out_held", out, 16'h0000);

      // main shifts
      run_op("lsl15", 16'h0001, 2'b01, 4'd15, 16'h8000, 16);
      @(negedge clk);
      check_eq("lsl15_done_pulse", done, 1'b0);
      check_eq("lsl15_out_held", out, 16'h8000);
      check_eq("lsl15_idle_state", state_dbg, 2'd0);
      run_op("lsr15", 16'h8000, 2'b10, 4'd15, 16'h0001, 16);
      @(negedge clk);
      run_op("asr15", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 16);
      @(negedge clk);
      run_op("asr3", 16'hA5F0, 2'b11, 4'd3, 16'hF4BE, 4);
      @(negedge clk);
      run_op("amt0", 16'hBEEF, 2'b01, 4'd0, 16'hBEEF, 1);
      @(negedge clk);
      check_eq("amt0_done_pulse", done, 1'b0);
      run_op("pass7", 16'h5A5A, 2'b00, 4'd7, 16'h5A5A, 1);
      @(negedge clk);

      // start held through SHIFT is ignored, then accepted in DONE
      start = 1'b1; in = 16'h00F0; op = 2'b10; amount = 4'd4;
      @(posedge clk);
      @(negedge clk);
      in = 16'hFFFF; amount = 4'd0;
      lat = 1; busy_cnt = 0;
      while (!done && lat <= 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check_eq("hold_latency", lat, 5);
      check_eq("hold_busy_cycles", busy_cnt, 4);
      check_eq("hold_first_out", out, 16'h000F);
      @(negedge clk);
      check_eq("hold_second_done", done, 1'b1);
      check_eq("hold_second_out", out, 16'hFFFF);
      start = 1'b0;
      @(negedge clk);
      check_eq("hold_idle_done", done, 1'b0);
      check_eq("hold_idle_out", out, 16'hFFFF);

      // back-to-back: the next start is issued during the DONE cycle
      run_op("b2b_a", 16'h0001, 2'b01, 4'd15, 16'h8000, 16);
      run_op("b2b_b", 16'h0003, 2'b01, 4'd2, 16'h000C, 3);
      run_op("b2b_c", 16'h00FF, 2'b10, 4'd1, 16'h007F, 2);
      @(negedge clk);
      check_eq("b2b_done_pulse", done, 1'b0);
      check_eq("b2b_shift_idle", shift, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
